// File: rtl/grid_write_arbiter.sv
// Single write port arbiter for the snake grid register: round-robin among head,
// tail and food requesters, plus a board-clear sweep that owns the port while active.
module grid_write_arbiter #(
    parameter int                 GRID_W     = 32,
    parameter int                 GRID_H     = 24,
    parameter int                 X_W        = 5,
    parameter int                 Y_W        = 5,
    parameter int                 CODE_W     = 4,
    parameter logic [CODE_W-1:0]  CLEAR_CODE = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [2:0]            req,
    input  logic [3*X_W-1:0]      req_x,
    input  logic [3*Y_W-1:0]      req_y,
    input  logic [3*CODE_W-1:0]   req_code,
    input  logic                  wr_hold,
    input  logic                  clear_start,
    output logic [2:0]            gnt,
    output logic                  wr_en,
    output logic [X_W-1:0]        wr_x,
    output logic [Y_W-1:0]        wr_y,
    output logic [CODE_W-1:0]     wr_code,
    output logic                  clear_busy,
    output logic                  clear_done
);

    localparam int              NUM_REQ = 3;
    localparam logic [X_W-1:0]  X_LAST  = X_W'(GRID_W - 1);
    localparam logic [Y_W-1:0]  Y_LAST  = Y_W'(GRID_H - 1);

    // ST_DONE exists so clear_done lands one cycle after the final sweep write.
    typedef enum logic [1:0] {
        ST_ARB,
        ST_CLEAR,
        ST_DONE
    } state_t;

    state_t              state, state_d;
    logic [1:0]          rr_last, rr_last_d;
    logic [X_W-1:0]      sweep_x, sweep_x_d;
    logic [Y_W-1:0]      sweep_y, sweep_y_d;

    logic [2:0]          gnt_d;
    logic                wr_en_d;
    logic [X_W-1:0]      wr_x_d;
    logic [Y_W-1:0]      wr_y_d;
    logic [CODE_W-1:0]   wr_code_d;
    logic                clear_busy_d;
    logic                clear_done_d;

    logic [2:0]          eligible;
    logic                pick_valid;
    logic [1:0]          pick_idx;
    logic [1:0]          cand;

    // A requester is masked during its own grant cycle, before it can react to gnt.
    assign eligible = req & ~gnt;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        pick_valid = 1'b0;
        pick_idx   = 2'd0;
        cand       = rr_last;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = (cand == 2'd2) ? 2'd0 : cand + 2'd1;
            if (!pick_valid && eligible[cand]) begin
                pick_valid = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d      = state;
        rr_last_d    = rr_last;
        sweep_x_d    = sweep_x;
        sweep_y_d    = sweep_y;
        gnt_d        = 3'b000;
        wr_en_d      = 1'b0;
        wr_x_d       = wr_x;
        wr_y_d       = wr_y;
        wr_code_d    = wr_code;
        clear_busy_d = 1'b0;
        clear_done_d = 1'b0;

        unique case (state)
            ST_ARB: begin
                if (clear_start) begin
                    state_d      = ST_CLEAR;
                    sweep_x_d    = '0;
                    sweep_y_d    = '0;
                    clear_busy_d = 1'b1;
                end else if (!wr_hold && pick_valid) begin
                    gnt_d     = 3'b001 << pick_idx;
                    wr_en_d   = 1'b1;
                    wr_x_d    = req_x[pick_idx*X_W +: X_W];
                    wr_y_d    = req_y[pick_idx*Y_W +: Y_W];
                    wr_code_d = req_code[pick_idx*CODE_W +: CODE_W];
                    rr_last_d = pick_idx;
                end
            end

            ST_CLEAR: begin
                clear_busy_d = 1'b1;
                if (!wr_hold) begin
                    wr_en_d   = 1'b1;
                    wr_x_d    = sweep_x;
                    wr_y_d    = sweep_y;
                    wr_code_d = CLEAR_CODE;
                    if (sweep_x == X_LAST) begin
                        sweep_x_d = '0;
                        if (sweep_y == Y_LAST) begin
                            state_d = ST_DONE;
                        end else begin
                            sweep_y_d = sweep_y + 1'b1;
                        end
                    end else begin
                        sweep_x_d = sweep_x + 1'b1;
                    end
                end
            end

            ST_DONE: begin
                clear_done_d = 1'b1;
                state_d      = ST_ARB;
            end

            default: begin
                state_d = ST_ARB;
            end
        endcase
    end

    // rr_last starts at 2 so requester 0 is first in line after reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_ARB;
            rr_last    <= 2'd2;
            sweep_x    <= '0;
            sweep_y    <= '0;
            gnt        <= 3'b000;
            wr_en      <= 1'b0;
            wr_x       <= '0;
            wr_y       <= '0;
            wr_code    <= '0;
            clear_busy <= 1'b0;
            clear_done <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state      <= state_d;
            rr_last    <= rr_last_d;
            sweep_x    <= sweep_x_d;
            sweep_y    <= sweep_y_d;
            gnt        <= gnt_d;
            wr_en      <= wr_en_d;
            wr_x       <= wr_x_d;
            wr_y       <= wr_y_d;
            wr_code    <= wr_code_d;
            clear_busy <= clear_busy_d;
            clear_done <= clear_done_d;
        end
    end

endmodule

// File: tb/tb_grid_write_arbiter.sv
// Directed bench for grid_write_arbiter: table of arbitration vectors, then
// hand-written board-clear, wr_hold and reset-mid-clear sequences.
module tb_grid_write_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  req;
    logic [14:0] req_x;
    logic [14:0] req_y;
    logic [11:0] req_code;
    logic        wr_hold;
    logic        clear_start;
    logic [2:0]  gnt;
    logic        wr_en;
    logic [4:0]  wr_x;
    logic [4:0]  wr_y;
    logic [3:0]  wr_code;
    logic        clear_busy;
    logic        clear_done;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    grid_write_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .req_x       (req_x),
        .req_y       (req_y),
        .req_code    (req_code),
        .wr_hold     (wr_hold),
        .clear_start (clear_start),
        .gnt         (gnt),
        .wr_en       (wr_en),
        .wr_x        (wr_x),
        .wr_y        (wr_y),
        .wr_code     (wr_code),
        .clear_busy  (clear_busy),
        .clear_done  (clear_done)
    );

    typedef struct {
        logic [2:0]  req;
        logic [14:0] rx;
        logic [14:0] ry;
        logic [11:0] rc;
        logic        hold;
        logic [2:0]  gnt;
        logic        we;
        logic [4:0]  x;
        logic [4:0]  y;
        logic [3:0]  code;
    } vec_t;

    localparam int NUM_VEC = 19;
    vec_t tbl [NUM_VEC];

    function automatic logic [14:0] p5(input int a0, input int a1, input int a2);
        return {5'(a2), 5'(a1), 5'(a0)};
    endfunction

    function automatic logic [11:0] p4(input int a0, input int a1, input int a2);
        return {4'(a2), 4'(a1), 4'(a0)};
    endfunction

    function automatic vec_t mk(input logic [2:0] r, input logic [14:0] rx, input logic [14:0] ry,
                                input logic [11:0] rc, input logic h, input logic [2:0] g,
                                input int x, input int y, input int c);
        vec_t v;
        v.req  = r;
        v.rx   = rx;
        v.ry   = ry;
        v.rc   = rc;
        v.hold = h;
        v.gnt  = g;
        v.we   = (g != 3'b000);
        v.x    = 5'(x);
        v.y    = 5'(y);
        v.code = 4'(c);
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Follows one clear sweep until clear_done; optionally holds the port before
    // (hx,hy) for hlen cycles and pokes clear_start mid-sweep.
    task automatic sweep(input int hx, input int hy, input int hlen, input bit poke,
                         output int writes, output int span, output int bad, output bit saw_done);
        int ex, ey, first, last, held;
        bit holding;
        ex = 0; ey = 0; first = -1; last = -1; held = 0; holding = 1'b0;
        writes = 0; bad = 0; saw_done = 1'b0;
        for (int cyc = 0; cyc < 1000 && !saw_done; cyc++) begin
            @(posedge clk); #1;
            clear_start = 1'b0;
            if (clear_done) begin
                saw_done = 1'b1;
                if (wr_en || clear_busy || gnt != 3'b000) bad++;
            end else begin
                if (!clear_busy || gnt != 3'b000) bad++;
                if (holding) begin
                    if (wr_en) bad++;
                    held++;
                    if (held == hlen) begin
                        holding = 1'b0;
                        wr_hold = 1'b0;
                    end
                end else if (wr_en) begin
                    if (wr_x != 5'(ex) || wr_y != 5'(ey) || wr_code != 4'd0) bad++;
                    writes++;
                    if (first < 0) first = cyc;
                    last = cyc;
                    ex++;
                    if (ex == 32) begin
                        ex = 0;
                        ey++;
                    end
                    if (hlen > 0 && wr_x == 5'(hx - 1) && wr_y == 5'(hy)) begin
                        holding = 1'b1;
                        wr_hold = 1'b1;
                    end
                    if (poke && wr_x == 5'd20 && wr_y == 5'd10) clear_start = 1'b1;
                end
            end
        end
        wr_hold     = 1'b0;
        clear_start = 1'b0;
        span = (first >= 0) ? (last - first + 1) : 0;
    endtask

    task automatic start_clear();
        @(negedge clk);
        clear_start = 1'b1;
        @(posedge clk); #1;
        clear_start = 1'b0;
    endtask

    initial begin
        int  writes, span, bad;
        bit  done, found, seen;
        logic [13:0] act_pay, exp_pay;

        tbl[0]  = mk(3'b000, p5(0,0,0),     p5(0,0,0),     p4(0,0,0),     1'b0, 3'b000, 0, 0, 0);
        tbl[1]  = mk(3'b111, p5(1,4,7),     p5(2,5,8),     p4(3,6,9),     1'b0, 3'b001, 1, 2, 3);
        tbl[2]  = mk(3'b111, p5(10,4,7),    p5(11,5,8),    p4(12,6,9),    1'b0, 3'b010, 4, 5, 6);
        tbl[3]  = mk(3'b111, p5(10,13,7),   p5(11,14,8),   p4(12,15,9),   1'b0, 3'b100, 7, 8, 9);
        tbl[4]  = mk(3'b111, p5(10,13,16),  p5(11,14,17),  p4(12,15,1),   1'b0, 3'b001, 10, 11, 12);
        tbl[5]  = mk(3'b111, p5(19,13,16),  p5(20,14,17),  p4(2,15,1),    1'b0, 3'b010, 13, 14, 15);
        tbl[6]  = mk(3'b111, p5(19,22,16),  p5(20,23,17),  p4(2,3,1),     1'b0, 3'b100, 16, 17, 1);
        tbl[7]  = mk(3'b111, p5(19,22,25),  p5(20,23,0),   p4(2,3,4),     1'b0, 3'b001, 19, 20, 2);
        tbl[8]  = mk(3'b000, p5(19,22,25),  p5(20,23,0),   p4(2,3,4),     1'b0, 3'b000, 0, 0, 0);
        tbl[9]  = mk(3'b010, p5(30,7,31),   p5(30,3,31),   p4(15,5,15),   1'b0, 3'b010, 7, 3, 5);
        tbl[10] = mk(3'b000, p5(30,7,31),   p5(30,3,31),   p4(15,5,15),   1'b0, 3'b000, 0, 0, 0);
        tbl[11] = mk(3'b010, p5(30,7,31),   p5(30,3,31),   p4(15,5,15),   1'b0, 3'b010, 7, 3, 5);
        tbl[12] = mk(3'b010, p5(30,7,31),   p5(30,3,31),   p4(15,5,15),   1'b0, 3'b000, 0, 0, 0);
        tbl[13] = mk(3'b000, p5(30,7,31),   p5(30,3,31),   p4(15,5,15),   1'b0, 3'b000, 0, 0, 0);
        tbl[14] = mk(3'b101, p5(9,0,21),    p5(8,0,22),    p4(7,0,11),    1'b1, 3'b000, 0, 0, 0);
        tbl[15] = mk(3'b101, p5(9,0,21),    p5(8,0,22),    p4(7,0,11),    1'b1, 3'b000, 0, 0, 0);
        tbl[16] = mk(3'b101, p5(9,0,21),    p5(8,0,22),    p4(7,0,11),    1'b0, 3'b100, 21, 22, 11);
        tbl[17] = mk(3'b001, p5(9,0,21),    p5(30,0,22),   p4(7,0,11),    1'b0, 3'b001, 9, 30, 7);
        tbl[18] = mk(3'b000, p5(9,0,21),    p5(30,0,22),   p4(7,0,11),    1'b0, 3'b000, 0, 0, 0);

        // Reset held with random inputs: outputs must stay at zero.
        rst = 1'b0;
        req = 3'b000; req_x = '0; req_y = '0; req_code = '0;
        wr_hold = 1'b0; clear_start = 1'b0;
        repeat (4) begin
            @(negedge clk);
            req         = 3'($urandom);
            req_x       = 15'($urandom);
            req_y       = 15'($urandom);
            req_code    = 12'($urandom);
            wr_hold     = 1'($urandom);
            clear_start = 1'($urandom);
        end
        @(posedge clk); #1;
        check("reset_outputs", 32'({gnt, wr_en, wr_x, wr_y, wr_code, clear_busy, clear_done}), 32'd0);
        @(negedge clk);
        req = 3'b000; req_x = '0; req_y = '0; req_code = '0;
        wr_hold = 1'b0; clear_start = 1'b0;
        rst = 1'b1;

        for (int i = 0; i < NUM_VEC; i++) begin
            @(negedge clk);
            req      = tbl[i].req;
            req_x    = tbl[i].rx;
            req_y    = tbl[i].ry;
            req_code = tbl[i].rc;
            wr_hold  = tbl[i].hold;
            @(posedge clk); #1;
            exp_pay = tbl[i].we ? {tbl[i].x, tbl[i].y, tbl[i].code} : 14'd0;
            act_pay = tbl[i].we ? {wr_x, wr_y, wr_code} : 14'd0;
            check($sformatf("vec%0d", i),
                  32'({gnt, wr_en, clear_busy, clear_done, act_pay}),
                  32'({tbl[i].gnt, tbl[i].we, 2'b00, exp_pay}));
        end

        // Full clear with requester 0 pending; clear_start must win the first cycle.
        @(negedge clk);
        req = 3'b001; req_x = p5(3,0,0); req_y = p5(4,0,0); req_code = p4(5,0,0);
        clear_start = 1'b1;
        @(posedge clk); #1;
        check("clear_start_wins", 32'({gnt, wr_en, clear_busy}), 32'({3'b000, 1'b0, 1'b1}));
        clear_start = 1'b0;
        sweep(0, 0, 0, 1'b0, writes, span, bad, done);
        check("clear_writes", 32'(writes), 32'd768);
        check("clear_order", 32'(bad), 32'd0);
        check("clear_span", 32'(span), 32'd768);
        check("clear_done_seen", 32'(done), 32'd1);
        @(posedge clk); #1;
        check("post_clear_grant", 32'({gnt, wr_en, clear_done, clear_busy, wr_x, wr_y, wr_code}),
              32'({3'b001, 1'b1, 1'b0, 1'b0, 5'd3, 5'd4, 4'd5}));
        req = 3'b000;

        // Clear with a 10-cycle hold before (12,4) and a stray clear_start mid-sweep.
        start_clear();
        sweep(12, 4, 10, 1'b1, writes, span, bad, done);
        check("hold_writes", 32'(writes), 32'd768);
        check("hold_order", 32'(bad), 32'd0);
        check("hold_span", 32'(span), 32'd778);
        check("hold_done_seen", 32'(done), 32'd1);
        @(posedge clk); #1;
        check("hold_after_done", 32'({gnt, wr_en, clear_busy, clear_done}), 32'd0);

        // Reset asserted at write (5,2): outputs clear at once, no clear_done follows.
        start_clear();
        found = 1'b0;
        for (int cyc = 0; cyc < 200 && !found; cyc++) begin
            @(posedge clk); #1;
            if (wr_en && wr_x == 5'd5 && wr_y == 5'd2) found = 1'b1;
        end
        check("reach_5_2", 32'(found), 32'd1);
        rst = 1'b0;
        #1;
        check("rst_mid_clear", 32'({gnt, wr_en, wr_x, wr_y, wr_code, clear_busy, clear_done}), 32'd0);
        seen = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            if (clear_done || clear_busy || wr_en) seen = 1'b1;
        end
        @(negedge clk);
        rst = 1'b1;
        repeat (4) begin
            @(posedge clk); #1;
            if (clear_done || clear_busy || wr_en) seen = 1'b1;
        end
        check("no_done_after_rst", 32'(seen), 32'd0);
        start_clear();
        sweep(0, 0, 0, 1'b0, writes, span, bad, done);
        check("reclear_writes", 32'(writes), 32'd768);
        check("reclear_order", 32'(bad), 32'd0);
        check("reclear_done_seen", 32'(done), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
